// File: rtl/stream_demux_1ton_pkg.sv
// Shared defaults and helpers for the 1:N stream demultiplexer.
package stream_demux_pkg;

  localparam int DW_DEF   = 8;
  localparam int N_DEF    = 6;
  localparam int CNTW_DEF = 8;

  typedef logic [CNTW_DEF-1:0] drop_cnt_t;

  // Codes N..2^SW-1 are unused when N is not a power of two.
  function automatic logic sel_is_legal(input int sel, input int n);
    return (sel < n);
  endfunction

endpackage

// File: rtl/stream_demux_1ton_if.sv
// Producer-side and consumer-side stream signals of the 1:N demux.
interface stream_demux_1ton_if #(
  parameter int DW   = 8,
  parameter int N    = 6,
  parameter int CNTW = 8
);
  localparam int SW = $clog2(N);

  logic                  in_valid;
  logic                  in_ready;
  logic [DW-1:0]         in_data;
  logic [SW-1:0]         in_sel;
  logic                  in_bcast;
  logic [N-1:0]          out_valid;
  logic [N-1:0]          out_ready;
  logic [N-1:0][DW-1:0]  out_data;
  logic                  err_sel;
  logic [CNTW-1:0]       drop_cnt;

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data, err_sel, drop_cnt
  );

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data, err_sel, drop_cnt
  );
endinterface

// File: rtl/stream_demux_1ton_chan_buf.sv
// One-entry output holding register; load wins over drain so a channel
// can take a new beat on the same edge its old one leaves.
module demux_chan_buf #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] din,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] dout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_1ton.sv
// Registered 1:N demux: unicast or atomic broadcast into per-channel
// one-entry buffers; illegal selects are swallowed and counted.
module stream_demux_1ton
  import stream_demux_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int N    = N_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input logic                clk,
  input logic                rst_n,
  stream_demux_1ton_if.slave s
);

  localparam int SW = $clog2(N);

  logic [N-1:0]         free;
  logic [N-1:0]         load;
  logic [N-1:0]         vld;
  logic [N-1:0][DW-1:0] dat;
  logic                 sel_ok;
  logic                 free_sel;
  logic                 in_rdy;
  logic                 acc;
  logic                 drop;

  always_comb begin
    free     = ~vld | s.out_ready;
    sel_ok   = sel_is_legal(32'(s.in_sel), N);
    free_sel = 1'b0;
    for (int k = 0; k < N; k++)
      if (s.in_sel == SW'(k)) free_sel = free[k];
    // Broadcast waits for every channel so all buffers load together.
    if (s.in_bcast)   in_rdy = &free;
    else if (!sel_ok) in_rdy = 1'b1;
    else              in_rdy = free_sel;
    acc  = s.in_valid & in_rdy;
    drop = acc & ~s.in_bcast & ~sel_ok;
    for (int k = 0; k < N; k++)
      load[k] = acc & (s.in_bcast | (s.in_sel == SW'(k)));
  end

  assign s.in_ready  = in_rdy;
  assign s.out_valid = vld;
  assign s.out_data  = dat;

  for (genvar k = 0; k < N; k++) begin : g_chan
    demux_chan_buf #(.DW(DW)) u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .din   (s.in_data),
      .ready (s.out_ready[k]),
      .valid (vld[k]),
      .dout  (dat[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s.err_sel  <= 1'b0;
      s.drop_cnt <= '0;
    end else if (drop) begin
      s.err_sel <= 1'b1;
      if (s.drop_cnt != '1) s.drop_cnt <= s.drop_cnt + CNTW'(1);
    end
  end

endmodule
